// File: rtl/cdb_arbiter_pkg.sv
// Shared core definitions for the common data bus: ROB tag/result widths, functional unit
// indices and the CDB beat layout used by the ROB and the reservation stations.
package cdb_arbiter_pkg;

    localparam int unsigned TAG_W   = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned N_UNITS = 4;

    localparam int unsigned UNIT_ALU  = 0;
    localparam int unsigned UNIT_MUL  = 1;
    localparam int unsigned UNIT_DIV  = 2;
    localparam int unsigned UNIT_LDST = 3;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              branch;
        logic              branch_taken;
    } cdb_beat_t;

    // A single requester still needs a 1-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate the request vector by the priority pointer,
// take the lowest set bit, then rotate the winner index back to unit numbering.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0] ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] winner,
    output logic             found
);

    localparam logic [PTR_W:0] N_WIDE = N_REQ[PTR_W:0];

    logic [N_REQ-1:0] rotated;
    logic [PTR_W-1:0] offset;
    logic [PTR_W:0]   sum;

    always_comb begin
        rotated = N_REQ'({req_valid, req_valid} >> ptr);

        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = PTR_W'(i);
            end
        end
        found = enable & (|rotated);

        // Unrotate: (offset + ptr) mod N_REQ without a divider.
        sum = {1'b0, offset} + {1'b0, ptr};
        if (sum >= N_WIDE) begin
            sum = sum - N_WIDE;
        end
        winner = sum[PTR_W-1:0];

        grant = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = found && (winner == PTR_W'(i));
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants one completed functional-unit result per cycle and
// registers it as the CDB beat seen by the ROB and reservation stations.
module cdb_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned TAG_W  = cdb_arbiter_pkg::TAG_W,
    parameter int unsigned DATA_W = cdb_arbiter_pkg::DATA_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*TAG_W-1:0]  req_tag,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_branch,
    input  logic [N_REQ-1:0]        req_branch_taken,
    output logic [N_REQ-1:0]        req_grant,
    output logic                    Cdb_valid,
    output logic [TAG_W-1:0]        Cdb_rd_tag,
    output logic [DATA_W-1:0]       Cdb_data,
    output logic                    Cdb_branch,
    output logic                    Cdb_branch_taken
);

    import cdb_arbiter_pkg::*;

    localparam int unsigned    PTR_W    = ptr_width(N_REQ);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0]  pick_grant;
    logic [PTR_W-1:0]  winner;
    logic              found;

    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_data;
    logic              sel_branch;
    logic              sel_branch_taken;

    logic              valid_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] data_q;
    logic              branch_q;
    logic              branch_taken_q;

    // Flush and reset both suppress the grant so no unit believes it was accepted.
    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .enable    (~flush & ~reset),
        .grant     (pick_grant),
        .winner    (winner),
        .found     (found)
    );

    assign req_grant = pick_grant;

    always_comb begin
        sel_tag          = '0;
        sel_data         = '0;
        sel_branch       = 1'b0;
        sel_branch_taken = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == PTR_W'(i)) begin
                sel_tag          = req_tag[i*TAG_W +: TAG_W];
                sel_data         = req_data[i*DATA_W +: DATA_W];
                sel_branch       = req_branch[i];
                sel_branch_taken = req_branch_taken[i];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (winner == PTR_LAST) ? '0 : winner + PTR_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q          <= '0;
            valid_q        <= 1'b0;
            tag_q          <= '0;
            data_q         <= '0;
            branch_q       <= 1'b0;
            branch_taken_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= found;
            // Payload fields hold on idle cycles; only Cdb_valid marks a fresh beat.
            if (found) begin
                tag_q          <= sel_tag;
                data_q         <= sel_data;
                branch_q       <= sel_branch;
                branch_taken_q <= sel_branch_taken;
            end
        end
    end

    assign Cdb_valid        = valid_q;
    assign Cdb_rd_tag       = tag_q;
    assign Cdb_data         = data_q;
    assign Cdb_branch       = branch_q;
    assign Cdb_branch_taken = branch_taken_q;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Round-robin arbiter for the Common Data Bus (CDB) in the Tomasulo-style MIPS core.
- Functional units (integer ALU, multiplier, divider, load/store) offer completed results. One is granted per cycle and driven as a registered CDB beat into the ROB update port and the reservation stations.
- Starvation-free.
- Flush input discards the beat in flight on a mispredicted-branch retire.

## Interface
Parameters:
- N_REQ, 4, number of requesting units; index 0 = ALU, 1 = MUL, 2 = DIV, 3 = LDST.
- TAG_W, 5, ROB tag width.
- DATA_W, 32, result width.

Ports:
- clock  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- flush  in  1  branch-mispredict flush, synchronous.
- req_valid  in  N_REQ  per-unit result available.
- req_tag  in  N_REQ*TAG_W  per-unit ROB tag; unit i occupies bits [i*TAG_W +: TAG_W].
- req_data  in  N_REQ*DATA_W  per-unit result, packed the same way.
- req_branch  in  N_REQ  result belongs to a branch.
- req_branch_taken  in  N_REQ  branch resolved taken.
- req_grant  out  N_REQ  one-hot (or zero) combinational grant.
- Cdb_valid  out  1  registered CDB beat valid.
- Cdb_rd_tag  out  TAG_W  registered tag.
- Cdb_data  out  DATA_W  registered data.
- Cdb_branch  out  1  registered branch flag.
- Cdb_branch_taken  out  1  registered taken flag.

## Operation
- Reset values: Cdb_valid=0, Cdb_rd_tag=0, Cdb_data=0, Cdb_branch=0, Cdb_branch_taken=0, priority pointer ptr=0. req_grant=0 while reset is high.
- Handshake:
  - A unit holds req_valid and its payload stable until it sees req_grant[i]=1 in the same cycle.
  - The unit drops or replaces its request in the next cycle.
  - Payload is never sampled without a grant.
- Selection (combinational):
  - Scan indices ptr, ptr+1, …, ptr+N_REQ-1, modulo N_REQ.
  - The first index with req_valid=1 wins.
  - req_grant is one-hot on the winner; it is all zero if there are no requests or flush=1.
- Pointer update (registered):
  - On a grant to unit i, ptr <= (i+1) mod N_REQ.
  - With no grant, ptr holds.
  - ptr width is clog2(N_REQ); it wraps from N_REQ-1 to 0.
- Output register:
  - Each edge loads Cdb_* from the winner's payload, with Cdb_valid=1.
  - With no winner, Cdb_valid<=0 and the other Cdb_* fields hold their last value.
- Flush:
  - flush=1 forces req_grant=0 and Cdb_valid<=0; ptr holds.
  - Requesters keep their requests and the units themselves discard them. No request is lost inside the arbiter.
- Simultaneous requests: all four valid with ptr=0 gives grants to 0, 1, 2, 3, 0, … on consecutive cycles.
- Reset mid-operation:
  - Asynchronous clear of all outputs and ptr.
  - Any pending request is re-arbitrated from ptr=0 after reset releases.

## Timing
- Grant latency: 0 cycles (grant is combinational from req_valid and ptr).
- CDB latency: 1 cycle. A payload granted at edge k appears on Cdb_* after edge k, valid for exactly one cycle.
- Throughput: 1 beat per cycle.
- Worst-case wait for a continuously requesting unit: N_REQ-1 cycles.
- No combinational path from req_* to Cdb_*. The only combinational paths are req_valid/flush/ptr -> req_grant.

## Structure
- Shared core package holds:
  - TAG_W = 5 and DATA_W = 32 (common with the ROB and the reservation stations).
  - Unit index constants UNIT_ALU, UNIT_MUL, UNIT_DIV, UNIT_LDST.
  - CDB beat struct {valid, tag, data, branch, branch_taken}.
- One sub-module: rr_pick.
  - Combinational rotate / priority-encode / unrotate of req_valid by ptr.
  - Produces the one-hot grant and the winner index.
- Payload mux, pointer register and output register live in cdb_arbiter.

## Test plan
- Reset, then a single request: reset high 2 cycles; after release, req_valid=0010, tag=7, data=0xDEADBEEF -> req_grant=0010 in the same cycle; next cycle Cdb_valid=1, tag=7, data=0xDEADBEEF; ptr=2.
- Full contention fairness: req_valid=1111 held 8 cycles from ptr=0 -> grant sequence 0,1,2,3,0,1,2,3; Cdb_valid=1 every cycle.
- Pointer skip and wrap: ptr=3, req_valid=0101 -> grant unit 0; ptr becomes 1; next grant unit 2.
- Flush: req_valid=1000 with flush=1 for one cycle -> req_grant=0, Cdb_valid=0 next cycle, ptr unchanged; flush=0 next cycle -> unit 3 granted.
- Branch fields: unit 0 with req_branch=1, req_branch_taken=1, tag=12 -> Cdb_branch=1, Cdb_branch_taken=1, Cdb_rd_tag=12 one cycle later; following idle cycle Cdb_valid=0.
- Asynchronous reset mid-stream: assert reset between edges during the full-contention run -> all Cdb_* outputs 0 immediately; first grant after release goes to unit 0.
